trig_unit_seq: RTL and testbench
================================

// Module: trig_unit_seq
// PURPOSE
//  Sequential sine/cosine unit for the 3D object transform path. It accepts a signed integer angle in
//  degrees, reduces it to [0,360) and folds it onto a quarter-wave ROM. The single ROM port is shared:
//  sine and cosine are looked up in consecutive cycles. Results are signed binary fixed point, Q1.FRAC_W.
//  Valid/ready handshakes on both sides let the rotation pipeline stall it.
// PARAMETERS
//  ANGLE_W  10  width of signed two's-complement input angle, degrees; legal 10..16
//  FRAC_W   12  fractional bits of outputs; output width OUT_W = FRAC_W+2; legal 8..16
// PORTS
//  clock       in   1         single clock; all state changes on rising edge
//  reset       in   1         synchronous, active-high
//  in_valid    in   1         angle request present
//  in_ready    out  1         unit can accept; high only in IDLE
//  in_angle    in   ANGLE_W   signed angle, degrees
//  out_valid   out  1         sine/cosine/quadrant valid; held until accepted
//  out_ready   in   1         consumer accepts result
//  out_sin     out  OUT_W     signed round(sin(a)*2^FRAC_W)
//  out_cos     out  OUT_W     signed round(cos(a)*2^FRAC_W)
//  out_quad    out  2         quadrant of reduced angle: 0:[0,90) 1:[90,180) 2:[180,270) 3:[270,360)
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; out_sin=0; out_cos=0; out_quad=0. A reset mid-operation discards the request.
//  ROM: 91 entries, rom[k]=round(sin(k deg)*2^FRAC_W), k=0..90, unsigned FRAC_W+1 bits; constant table, no init files.
//  FSM states: IDLE, REDUCE, FOLD, LOOK_SIN, LOOK_COS, DONE.
//   IDLE: in_valid&in_ready -> capture in_angle, sign-extended to ANGLE_W+2 bits, into acc; go to REDUCE.
//   REDUCE: one step per cycle. acc<0 -> acc+=360. acc>=360 -> acc-=360. Otherwise go to FOLD.
//   FOLD: q = 0,1,2,3 for acc in [0,90),[90,180),[180,270),[270,360); register q, indices and signs.
//    sin: q0 +rom[a]; q1 +rom[180-a]; q2 -rom[a-180]; q3 -rom[360-a]
//    cos: q0 +rom[90-a]; q1 -rom[a-90]; q2 -rom[270-a]; q3 +rom[a-270]
//   LOOK_SIN: read ROM at sin index, apply sign, register out_sin.
//   LOOK_COS: read ROM at cos index, apply sign, register out_cos and out_quad.
//   LOOK_COS -> DONE; out_valid=1 in DONE.
//   DONE: hold all outputs stable while out_ready=0. out_ready=1 -> out_valid=0 next cycle, go to IDLE.
//  Negation of zero yields 0; outputs never exceed +/-2^FRAC_W.
//  Latency: accept at edge ending cycle t. Then REDUCE occupies t+1..t+1+k, where k = number of reduction steps.
//   out_valid rises at cycle t+5+k.
//   k=0 for [0,360); for ANGLE_W=10, k<=2.
//   Request-to-request throughput: 6+k cycles minimum.
//  in_valid while not IDLE is ignored: in_ready=0, no capture. in_angle changes after capture have no effect.
//  In DONE, in_ready stays 0 even if out_ready=1; the next request is accepted in IDLE.
//  out_sin/out_cos retain their last values after handshake until overwritten.
// TESTING
//  1. a=30, FRAC_W=12 -> sin=2048, cos=3547, quad=0; out_valid at accept+5.
//  2. a=0 / a=90 / a=180 -> (0,4096,q0) / (4096,0,q1) / (0,-4096,q2); no -0 artefacts.
//  3. a=-30 -> sin=-2048, cos=3547, quad=3, latency 6. a=400 -> sin=2633, cos=3138, quad=0, latency 6.
//  4. a=-512 (ANGLE_W=10) -> reduces to 208: sin=-1923, cos=-3617, quad=2, latency 7.
//  5. out_ready low 10 cycles in DONE -> outputs stable, in_ready=0, extra in_valid ignored; then release -> IDLE.
//  6. reset asserted in LOOK_SIN -> next cycle IDLE, out_valid=0, outputs 0; fresh a=45 -> sin=cos=2896.

Source files
------------

// File: rtl/trig_unit_seq.sv
// trig_unit_seq: sequential sine/cosine of an integer degree angle.
// Angle is reduced to [0,360), folded onto a shared quarter-wave ROM.
module trig_unit_seq #(
  parameter int ANGLE_W = 10,
  parameter int FRAC_W  = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [ANGLE_W-1:0] in_angle,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [FRAC_W+1:0]  out_sin,
  output logic signed [FRAC_W+1:0]  out_cos,
  output logic [1:0]                out_quad
);

  localparam int OUT_W = FRAC_W + 2;
  localparam int ACC_W = ANGLE_W + 2;
  localparam logic signed [ACC_W-1:0] DEG360 = ACC_W'(360);
  localparam logic [127:0] PI_Q40 = 128'h3243F6A8885;

  // Elaboration-time sine in Q.40 (Taylor series), rounded to FRAC_W bits.
  function automatic logic [FRAC_W:0] sin_q(input int k);
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] pos;
    logic [127:0] neg;
    logic [127:0] s;
    x    = (128'(k) * PI_Q40) / 128'd180;
    x2   = (x * x) >> 40;
    term = x;
    pos  = x;
    neg  = '0;
    for (int n = 1; n <= 12; n++) begin
      term = ((term * x2) >> 40) / 128'((2 * n) * (2 * n + 1));
      if ((n % 2) == 1) neg = neg + term;
      else              pos = pos + term;
    end
    s = pos - neg;
    return (FRAC_W+1)'((s + (128'd1 << (39 - FRAC_W))) >> (40 - FRAC_W));
  endfunction

  logic [FRAC_W:0] rom [128];

  for (genvar k = 0; k < 128; k++) begin : g_rom
    if (k <= 90) begin : g_val
      localparam logic [FRAC_W:0] V = sin_q(k);
      assign rom[k] = V;
    end else begin : g_pad
      assign rom[k] = '0;
    end
  end

  typedef enum logic [2:0] {
    IDLE, REDUCE, FOLD, LOOK_SIN, LOOK_COS, DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [ACC_W-1:0] acc;
  logic [6:0] sin_idx;
  logic [6:0] cos_idx;
  logic       sin_neg;
  logic       cos_neg;
  logic [1:0] quad;

  logic [8:0] a;
  logic [6:0] f_sin_idx;
  logic [6:0] f_cos_idx;
  logic       f_sin_neg;
  logic       f_cos_neg;
  logic [1:0] f_quad;

  logic [6:0]             rom_idx;
  logic                   rom_neg;
  logic signed [OUT_W-1:0] mag;
  logic signed [OUT_W-1:0] val;

  logic acc_low;
  logic acc_high;

  assign acc_low  = acc < 0;
  assign acc_high = acc >= DEG360;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = REDUCE;
      end
      REDUCE: begin
        if (!acc_low && !acc_high) state_next = FOLD;
      end
      FOLD:     state_next = LOOK_SIN;
      LOOK_SIN: state_next = LOOK_COS;
      LOOK_COS: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    a         = acc[8:0];
    f_quad    = 2'd3;
    f_sin_idx = 7'(9'd360 - a);
    f_cos_idx = 7'(a - 9'd270);
    f_sin_neg = 1'b1;
    f_cos_neg = 1'b0;
    unique case (1'b1)
      (a < 9'd90): begin
        f_quad    = 2'd0;
        f_sin_idx = 7'(a);
        f_cos_idx = 7'(9'd90 - a);
        f_sin_neg = 1'b0;
        f_cos_neg = 1'b0;
      end
      (a >= 9'd90 && a < 9'd180): begin
        f_quad    = 2'd1;
        f_sin_idx = 7'(9'd180 - a);
        f_cos_idx = 7'(a - 9'd90);
        f_sin_neg = 1'b0;
        f_cos_neg = 1'b1;
      end
      (a >= 9'd180 && a < 9'd270): begin
        f_quad    = 2'd2;
        f_sin_idx = 7'(a - 9'd180);
        f_cos_idx = 7'(9'd270 - a);
        f_sin_neg = 1'b1;
        f_cos_neg = 1'b1;
      end
      default: ;
    endcase
  end

  // One ROM port: sine index in LOOK_SIN, cosine index otherwise.
  always_comb begin
    rom_idx = cos_idx;
    rom_neg = cos_neg;
    if (state == LOOK_SIN) begin
      rom_idx = sin_idx;
      rom_neg = sin_neg;
    end
    mag = $signed({1'b0, rom[rom_idx]});
    val = rom_neg ? -mag : mag;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc      <= '0;
      sin_idx  <= '0;
      cos_idx  <= '0;
      sin_neg  <= 1'b0;
      cos_neg  <= 1'b0;
      quad     <= '0;
      out_sin  <= '0;
      out_cos  <= '0;
      out_quad <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) acc <= {{2{in_angle[ANGLE_W-1]}}, in_angle};
        end
        REDUCE: begin
          if (acc_low)       acc <= acc + DEG360;
          else if (acc_high) acc <= acc - DEG360;
        end
        FOLD: begin
          sin_idx <= f_sin_idx;
          cos_idx <= f_cos_idx;
          sin_neg <= f_sin_neg;
          cos_neg <= f_cos_neg;
          quad    <= f_quad;
        end
        LOOK_SIN: out_sin <= val;
        LOOK_COS: begin
          out_cos  <= val;
          out_quad <= quad;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_unit_seq.sv
// tb_trig_unit_seq: directed and random checks of trig_unit_seq
// against a real-valued trigonometric reference model.
module tb_trig_unit_seq;

  localparam int ANGLE_W = 10;
  localparam int FRAC_W  = 12;
  localparam int OUT_W   = FRAC_W + 2;

  logic                      clock;
  logic                      reset;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [ANGLE_W-1:0] in_angle;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   out_sin;
  logic signed [OUT_W-1:0]   out_cos;
  logic [1:0]                out_quad;

  int checks;
  int failures;

  trig_unit_seq #(.ANGLE_W(ANGLE_W), .FRAC_W(FRAC_W)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_angle(in_angle),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sin(out_sin),
    .out_cos(out_cos),
    .out_quad(out_quad)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  // Reference: reduce with modulo, compute trig in reals, count steps.
  task automatic model(input int ang, output int s, output int c,
                       output int q, output int lat);
    int r;
    int k;
    real rad;
    r = ((ang % 360) + 360) % 360;
    if (ang < 0)        k = (-ang + 359) / 360;
    else if (ang >= 360) k = ang / 360;
    else                k = 0;
    rad = r * 3.14159265358979323846 / 180.0;
    s   = rnd($sin(rad) * 4096.0);
    c   = rnd($cos(rad) * 4096.0);
    q   = r / 90;
    lat = 5 + k;
  endtask

  // Issue one request from IDLE; return at the first negedge with out_valid.
  task automatic transact(input int ang, output int s, output int c,
                          output int q, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    in_valid = 1'b1;
    in_angle = ANGLE_W'(ang);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_angle = ANGLE_W'($urandom);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!out_valid && lat < 50);
    s = out_sin;
    c = out_cos;
    q = out_quad;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_sin !== '0 || out_cos !== '0 || out_quad !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: got sin=%0d cos=%0d quad=%0d expected 0 0 0",
               out_sin, out_cos, out_quad);
    end
  endtask

  task automatic test_directed();
    int ang [8]  = '{30, 0, 90, 180, -30, 400, -512, 45};
    int esin [8] = '{2048, 0, 4096, 0, -2048, 2633, -1923, 2896};
    int ecos [8] = '{3547, 4096, 0, -4096, 3547, 3138, -3617, 2896};
    int equad [8] = '{0, 1, 1, 2, 3, 0, 2, 0};
    int elat [8] = '{5, 5, 5, 5, 6, 6, 7, 5};
    int s, c, q, lat;
    equad[1] = 0;
    for (int i = 0; i < 8; i++) begin
      transact(ang[i], s, c, q, lat);
      checks++;
      if (s !== esin[i] || c !== ecos[i] || q !== equad[i] || lat !== elat[i]) begin
        failures++;
        $display("FAIL directed a=%0d: got sin=%0d cos=%0d quad=%0d lat=%0d expected %0d %0d %0d %0d",
                 ang[i], s, c, q, lat, esin[i], ecos[i], equad[i], elat[i]);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL directed_busy a=%0d: got in_ready=%b expected 0", ang[i], in_ready);
      end
      release_out();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
          out_sin !== OUT_W'(esin[i]) || out_cos !== OUT_W'(ecos[i])) begin
        failures++;
        $display("FAIL directed_after a=%0d: got valid=%b ready=%b sin=%0d cos=%0d expected 0 1 %0d %0d",
                 ang[i], out_valid, in_ready, out_sin, out_cos, esin[i], ecos[i]);
      end
    end
  endtask

  task automatic test_random();
    int ang, s, c, q, lat;
    int ms, mc, mq, mlat;
    for (int i = 0; i < 40; i++) begin
      ang = int'($urandom_range(0, 1023)) - 512;
      model(ang, ms, mc, mq, mlat);
      transact(ang, s, c, q, lat);
      checks++;
      if (s !== ms || c !== mc || q !== mq || lat !== mlat) begin
        failures++;
        $display("FAIL random a=%0d: got sin=%0d cos=%0d quad=%0d lat=%0d expected %0d %0d %0d %0d",
                 ang, s, c, q, lat, ms, mc, mq, mlat);
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
      release_out();
    end
  endtask

  task automatic test_stall();
    int s, c, q, lat;
    int ms, mc, mq, mlat;
    int bad;
    model(-200, ms, mc, mq, mlat);
    transact(-200, s, c, q, lat);
    checks++;
    if (s !== ms || c !== mc || q !== mq || lat !== mlat) begin
      failures++;
      $display("FAIL stall_result: got sin=%0d cos=%0d quad=%0d lat=%0d expected %0d %0d %0d %0d",
               s, c, q, lat, ms, mc, mq, mlat);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_angle = ANGLE_W'($urandom);
      @(negedge clock);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sin !== OUT_W'(ms) ||
          out_cos !== OUT_W'(mc) || out_quad !== 2'(mq)) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad);
    end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int s, c, q, lat;
    int ms, mc, mq, mlat;
    for (int i = 0; i < 3; i++) begin
      model(100 + 120 * i, ms, mc, mq, mlat);
      transact(100 + 120 * i, s, c, q, lat);
      checks++;
      if (s !== ms || c !== mc || q !== mq || lat !== mlat) begin
        failures++;
        $display("FAIL b2b a=%0d: got sin=%0d cos=%0d quad=%0d lat=%0d expected %0d %0d %0d %0d",
                 100 + 120 * i, s, c, q, lat, ms, mc, mq, mlat);
      end
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int s, c, q, lat;
    in_valid = 1'b1;
    in_angle = ANGLE_W'(123);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sin !== '0 ||
        out_cos !== '0 || out_quad !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid: got ready=%b valid=%b sin=%0d cos=%0d quad=%0d expected 1 0 0 0 0",
               in_ready, out_valid, out_sin, out_cos, out_quad);
    end
    transact(45, s, c, q, lat);
    checks++;
    if (s !== 2896 || c !== 2896 || q !== 0 || lat !== 5) begin
      failures++;
      $display("FAIL reset_mid_fresh: got sin=%0d cos=%0d quad=%0d lat=%0d expected 2896 2896 0 5",
               s, c, q, lat);
    end
    release_out();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_angle  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
